router_pkt_tx: RTL and testbench

Packet transmitter for the router 1x3 input port. It accepts a packet command and a payload byte stream, and buffers the whole payload. It then drives `packet_valid`/`datain` to the router, emitting header, payload and parity. It honours the router's `busy` back-pressure, and serves as both the bench/system packet source and the upstream peer of the router FSM/register pair.

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_tx_buf.sv | 42 ++++
 rtl/router_pkt_tx.sv | 158 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Header fields, transmitter states and header packing shared by the router TX, FSM and register blocks.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int PTR_W  = LEN_W;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  function automatic hdr_t pack_hdr(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    hdr_t h;
    h.len  = len;
    h.addr = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: synchronous write, combinational read of the current and next read slot.
// Pointers clear together at the start of each packet; no wrap inside a packet.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [7:0]       rd_data,
  output logic [7:0]       nxt_data
);

  logic [7:0]       mem [MAX_LEN];
  logic [PTR_W-1:0] nxt_idx;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Clamp the look-ahead index so the last slot never reads past the array.
  assign nxt_idx  = (rd_ptr >= PTR_W'(MAX_LEN - 1)) ? rd_ptr : rd_ptr + PTR_W'(1);
  assign rd_data  = mem[rd_ptr];
  assign nxt_data = mem[nxt_idx];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers a whole payload, then sends header/payload/parity to the router; header follows the last loaded byte by one cycle.
// Every wire byte (and header launch) holds while busy is high; commands and payload use ready handshakes.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic             cmd_corrupt,
  input  logic             pld_valid,
  output logic             pld_ready,
  input  logic [7:0]       pld_data,
  input  logic             busy,
  output logic             packet_valid,
  output logic [7:0]       datain,
  output logic             done,
  output logic             drop,
  output logic [CNT_W-1:0] tx_count
);

  tx_state_e        state, state_n;
  hdr_t             hdr, hdr_n;
  logic             corrupt, corrupt_n;
  logic [7:0]       parity, parity_n;
  logic [7:0]       datain_n;
  logic             packet_valid_n, done_n, drop_n, cmd_ready_n, pld_ready_n;
  logic [CNT_W-1:0] tx_count_n;
  logic             buf_clr, wr_en, rd_en, loaded;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_cnt_n;
  logic [7:0]       rd_data, nxt_data;

  router_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (buf_clr),
    .wr_en    (wr_en),
    .wr_data  (pld_data),
    .rd_en    (rd_en),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .rd_data  (rd_data),
    .nxt_data (nxt_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      hdr          <= '0;
      corrupt      <= 1'b0;
      parity       <= '0;
      packet_valid <= 1'b0;
      datain       <= '0;
      done         <= 1'b0;
      drop         <= 1'b0;
      cmd_ready    <= 1'b1;
      pld_ready    <= 1'b0;
      tx_count     <= '0;
    end else begin
      state        <= state_n;
      hdr          <= hdr_n;
      corrupt      <= corrupt_n;
      parity       <= parity_n;
      packet_valid <= packet_valid_n;
      datain       <= datain_n;
      done         <= done_n;
      drop         <= drop_n;
      cmd_ready    <= cmd_ready_n;
      pld_ready    <= pld_ready_n;
      tx_count     <= tx_count_n;
    end
  end

  always_comb begin
    state_n        = state;
    hdr_n          = hdr;
    corrupt_n      = corrupt;
    parity_n       = parity;
    packet_valid_n = packet_valid;
    datain_n       = datain;
    done_n         = 1'b0;
    drop_n         = 1'b0;
    tx_count_n     = tx_count;
    buf_clr        = 1'b0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    loaded         = 1'b0;
    wr_cnt_n       = wr_ptr;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            drop_n = 1'b1;
          end else begin
            hdr_n     = pack_hdr(cmd_len, cmd_addr);
            corrupt_n = cmd_corrupt;
            parity_n  = hdr_n;
            buf_clr   = 1'b1;
            wr_cnt_n  = '0;
            state_n   = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        wr_en    = pld_valid && pld_ready;
        wr_cnt_n = wr_ptr + PTR_W'(wr_en);
        if (wr_en) parity_n = parity ^ pld_data;
        loaded = (wr_cnt_n == hdr.len);
        // A fully loaded packet waits here until the router is free to take a header.
        if (loaded && !busy) begin
          state_n        = ST_HEADER;
          packet_valid_n = 1'b1;
          datain_n       = hdr;
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          state_n  = ST_PAYLOAD;
          datain_n = rd_data;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (rd_ptr == hdr.len - 6'd1) begin
            state_n        = ST_PARITY;
            packet_valid_n = 1'b0;
            datain_n       = parity ^ {7'b0, corrupt};
          end else begin
            rd_en    = 1'b1;
            datain_n = nxt_data;
          end
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          state_n  = ST_GAP;
          datain_n = '0;
          done_n   = 1'b1;
        end
      end
      ST_GAP: begin
        state_n    = ST_IDLE;
        tx_count_n = tx_count + CNT_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    cmd_ready_n = (state_n == ST_IDLE);
    pld_ready_n = (state_n == ST_LOAD) && (wr_cnt_n != hdr_n.len);
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed vector table, max-length and reset corner sequences, and randomized packets scored by a queue model.
module tb_router_pkt_tx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [5:0]  cmd_len = '0;
  logic        cmd_corrupt = 1'b0;
  logic        pld_valid = 1'b0;
  logic [7:0]  pld_data = '0;
  logic        busy = 1'b0;
  logic        cmd_ready, pld_ready, packet_valid, done, drop;
  logic [7:0]  datain;
  logic [15:0] tx_count;

  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  logic [7:0]  pld [0:63];

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic       corrupt;
    logic [7:0] b0, b1, b2;
    int         stall_at;
    int         stall_n;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } vec_t;

  vec_t vecs [5];

  router_pkt_tx #(.MAX_LEN(63), .CNT_W(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_corrupt  (cmd_corrupt),
    .pld_valid    (pld_valid),
    .pld_ready    (pld_ready),
    .pld_data     (pld_data),
    .busy         (busy),
    .packet_valid (packet_valid),
    .datain       (datain),
    .done         (done),
    .drop         (drop),
    .tx_count     (tx_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Deterministic packet: busy held for stall_n cycles on wire byte stall_at (-1 = never).
  task automatic send_pkt(input string tag, input logic [1:0] addr, input logic [5:0] len,
                          input logic corrupt, input int stall_at, input int stall_n,
                          input bit toggle, input logic [7:0] exp_hdr, input logic [7:0] exp_par);
    int         n;
    int         early;
    int         bad;
    int         holds;
    logic [7:0] wb [0:64];
    logic       wv [0:64];
    n = int'(len);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_corrupt = corrupt;
    step();
    cmd_valid = 1'b0;
    check({tag, "_ready_load"}, 32'({cmd_ready, pld_ready}), 32'b01);
    early = 0;
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        pld_valid = 1'b0;
        step();
        if (packet_valid) early++;
      end
      pld_valid = 1'b1; pld_data = pld[i];
      step();
      if (i < n - 1 && packet_valid) early++;
    end
    pld_valid = 1'b0;
    check({tag, "_early_pv"}, early, 0);
    check({tag, "_hdr_latency"}, 32'({packet_valid, datain}), 32'({1'b1, exp_hdr}));
    wb[0] = exp_hdr; wv[0] = 1'b1;
    for (int i = 0; i < n; i++) begin
      wb[i + 1] = pld[i]; wv[i + 1] = 1'b1;
    end
    wb[n + 1] = exp_par; wv[n + 1] = 1'b0;
    bad = 0;
    for (int k = 0; k <= n + 1; k++) begin
      holds = (k == stall_at) ? stall_n : 0;
      for (int s = 0; s <= holds; s++) begin
        if ({packet_valid, datain} !== {wv[k], wb[k]}) begin
          if (bad == 0)
            $display("  %s wire byte %0d cycle %0d: pv=%0b d=%02h want pv=%0b d=%02h",
                     tag, k, s, packet_valid, datain, wv[k], wb[k]);
          bad++;
        end
        busy = (s < holds);
        step();
      end
    end
    busy = 1'b0;
    check({tag, "_wire_errors"}, bad, 0);
    check({tag, "_gap"}, 32'({done, packet_valid, datain}), 32'({1'b1, 1'b0, 8'h00}));
    step();
    exp_cnt++;
    check({tag, "_after_gap"}, 32'({done, cmd_ready}), 32'b01);
    check({tag, "_tx_count"}, 32'(tx_count), 32'(exp_cnt));
  endtask

  // Random payload gaps and busy; expected stream is derived from the framing rules alone.
  task automatic send_rand(input logic [1:0] addr, input logic [5:0] len, input logic corrupt);
    int         n, got, cyc, early, hold_err, bad;
    logic [7:0] exp_hdr, exp_par, eb;
    logic       ev;
    logic [7:0] got_b [$];
    logic       got_pv [$];
    logic       prev_pv, was_busy, started;
    logic [7:0] prev_d;
    n = int'(len);
    for (int i = 0; i < n; i++) pld[i] = 8'($urandom);
    exp_hdr = 8'(n * 4 + int'(addr));
    exp_par = exp_hdr;
    for (int i = 0; i < n; i++) exp_par = exp_par ^ pld[i];
    if (corrupt) exp_par = exp_par ^ 8'h01;

    check("rnd_cmd_ready", 32'(cmd_ready), 32'd1);
    busy = 1'($urandom_range(0, 1));
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_corrupt = corrupt;
    step();
    cmd_valid = 1'b0;
    got = 0; cyc = 0; early = 0;
    while (got < n && cyc < 500) begin
      pld_valid = 1'($urandom_range(0, 1));
      pld_data  = pld[got];
      busy      = 1'($urandom_range(0, 1));
      if (pld_valid && pld_ready) got++;
      step();
      cyc++;
      if (got < n && packet_valid) early++;
    end
    pld_valid = 1'b0;
    check("rnd_loaded", got, n);
    check("rnd_early_pv", early, 0);

    started = 1'b0; was_busy = 1'b0; prev_pv = 1'b0; prev_d = '0; hold_err = 0; cyc = 0;
    while (cyc < 1000) begin
      if (done) break;
      if (packet_valid) started = 1'b1;
      if (started) begin
        if (was_busy && {packet_valid, datain} !== {prev_pv, prev_d}) hold_err++;
        prev_pv  = packet_valid;
        prev_d   = datain;
        was_busy = ($urandom_range(0, 3) == 0);
        busy     = was_busy;
        if (!was_busy) begin
          got_b.push_back(datain);
          got_pv.push_back(packet_valid);
        end
      end else begin
        busy = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
    end
    busy = 1'b0;
    check("rnd_done_seen", 32'(done), 32'd1);
    check("rnd_hold_errors", hold_err, 0);
    check("rnd_wire_len", got_b.size(), n + 2);
    bad = 0;
    for (int k = 0; k < got_b.size() && k < n + 2; k++) begin
      eb = (k == 0) ? exp_hdr : (k <= n) ? pld[k - 1] : exp_par;
      ev = (k <= n);
      if ({got_pv[k], got_b[k]} !== {ev, eb}) bad++;
    end
    check("rnd_wire_errors", bad, 0);
    check("rnd_gap", 32'({packet_valid, datain}), 32'd0);
    step();
    exp_cnt++;
    check("rnd_tx_count", 32'(tx_count), 32'(exp_cnt));
  endtask

  logic [1:0] ra;
  logic [5:0] rl;
  logic [7:0] mpar;

  initial begin
    vecs[0] = '{2'd1, 6'd3, 1'b0, 8'hAA, 8'hBB, 8'hCC, -1, 0, 8'h0D, 8'hD0};
    vecs[1] = '{2'd1, 6'd3, 1'b0, 8'hAA, 8'hBB, 8'hCC,  2, 2, 8'h0D, 8'hD0};
    vecs[2] = '{2'd1, 6'd3, 1'b1, 8'hAA, 8'hBB, 8'hCC, -1, 0, 8'h0D, 8'hD1};
    vecs[3] = '{2'd0, 6'd2, 1'b0, 8'h01, 8'h02, 8'h00,  0, 1, 8'h08, 8'h0B};
    vecs[4] = '{2'd3, 6'd1, 1'b0, 8'hFF, 8'h00, 8'h00,  2, 3, 8'h07, 8'hF8};

    // Reset state
    resetn = 1'b0;
    step(); step();
    check("rst_pv_datain", 32'({packet_valid, datain}), 32'd0);
    check("rst_pulses", 32'({done, drop}), 32'd0);
    check("rst_ready", 32'({cmd_ready, pld_ready}), 32'b10);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    resetn = 1'b1;
    step();
    check("post_rst_tx_count", 32'(tx_count), 32'd0);

    for (int v = 0; v < 5; v++) begin
      pld[0] = vecs[v].b0; pld[1] = vecs[v].b1; pld[2] = vecs[v].b2;
      send_pkt($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].corrupt,
               vecs[v].stall_at, vecs[v].stall_n, 1'b0, vecs[v].exp_hdr, vecs[v].exp_par);
    end

    // Max length with toggling payload valid
    mpar = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pld[i] = 8'(i * 5 + 3);
      mpar = mpar ^ pld[i];
    end
    send_pkt("maxlen", 2'd2, 6'd63, 1'b0, -1, 0, 1'b1, 8'hFE, mpar);

    for (int r = 0; r < 20; r++) begin
      ra = 2'($urandom_range(0, 3));
      rl = (r < 3) ? 6'(r + 1) : 6'($urandom_range(1, 63));
      send_rand(ra, rl, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the payload, then a zero-length command
    for (int i = 0; i < 5; i++) pld[i] = 8'(8'h40 + i);
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd5; cmd_corrupt = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pld_valid = 1'b1; pld_data = pld[i];
      step();
    end
    pld_valid = 1'b0;
    step(); step();
    check("midrst_in_payload", 32'({packet_valid, datain}), 32'({1'b1, 8'h41}));
    resetn = 1'b0;
    step();
    exp_cnt = 0;
    check("midrst_pv", 32'(packet_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_tx_count", 32'(tx_count), 32'd0);
    resetn = 1'b1;
    step();
    check("midrst_no_done", 32'({done, packet_valid}), 32'd0);
    cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 6'd0;
    step();
    cmd_valid = 1'b0;
    check("len0_drop", 32'({drop, cmd_ready, packet_valid}), 32'b110);
    step();
    check("len0_after", 32'({drop, packet_valid, pld_ready, done}), 32'd0);
    check("len0_tx_count", 32'(tx_count), 32'd0);

    pld[0] = 8'hAA; pld[1] = 8'hBB; pld[2] = 8'hCC;
    send_pkt("recover", 2'd1, 6'd3, 1'b0, -1, 0, 1'b0, 8'h0D, 8'hD0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
